// File: rtl/led_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Default sizing lives here; instances derive their own widths from their parameters.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam int unsigned DIGITS_DEF   = 4;
  localparam int unsigned PRESCALE_DEF = 1000;
  localparam int unsigned CNT_W_DEF    = $clog2(PRESCALE_DEF);
  localparam int unsigned IDX_W_DEF    = $clog2(DIGITS_DEF);

  // Digit enable for a given position; at most 8 digits are supported.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/led_lz_mask.sv
// Leading-zero blank mask: a digit is blanked when it and every digit above it
// are zero; digit 0 always stays lit so a zero value still reads "0".
module led_lz_mask
  import led_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic [4*DIGITS-1:0] value,
  input  logic                lz_blank,
  output logic [DIGITS-1:0]   blank_mask
);

  logic zero_run;

  // Walk from the most significant digit down while the run of zeros holds.
  always_comb begin
    blank_mask = '0;
    zero_run   = lz_blank;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      zero_run      = zero_run & (value[4*i +: 4] == 4'h0);
      blank_mask[i] = zero_run;
    end
  end

endmodule

// File: rtl/led_scan_controller.sv
// Time-multiplexes one external 7-segment decoder across DIGITS digit positions,
// with a blank gap at the start of every slot to suppress ghosting.
module led_scan_controller
  import led_pkg::*;
#(
  parameter int unsigned DIGITS       = DIGITS_DEF,
  parameter int unsigned PRESCALE     = PRESCALE_DEF,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic                lz_blank,
  output logic [7:0]          digit_code,
  input  logic [7:0]          seg_in,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                frame_done
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [7:0]          seg_out_q, seg_out_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [7:0]          digit_code_q, digit_code_d;
  logic                frame_done_q, frame_done_d;
  logic [DIGITS-1:0]   lz_mask_s;
  logic [7:0]          oh_s;
  logic                snap_s;
  logic                unused_s;

  assign unused_s = seg_in[7];

  led_lz_mask #(.DIGITS(DIGITS)) u_lz_mask (
    .value      (value),
    .lz_blank   (lz_blank),
    .blank_mask (lz_mask_s)
  );

  // Next-state, snapshot and output decode; outputs follow the next state so
  // they line up with the state register rather than lagging it by a cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    snap_s       = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          snap_s  = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
          end else begin
            state_d = BLANK;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_W'(PRESCALE - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
              idx_d        = '0;
              snap_s       = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    if (snap_s) begin
      val_d  = value;
      dp_d   = dp_mask;
      mask_d = lz_mask_s;
    end else begin
      val_d  = val_q;
      dp_d   = dp_q;
      mask_d = mask_q;
    end

    oh_s = onehot(3'(idx_d));
    if (state_d == IDLE) begin
      digit_code_d = 8'h00;
    end else begin
      digit_code_d = {4'h0, val_d[{idx_d, 2'b00} +: 4]};
    end

    // seg_in is the decoder's view of digit_code_q, which is stable for the slot.
    if ((state_d == SHOW) && !mask_d[idx_d]) begin
      seg_out_d   = {dp_d[idx_d], seg_in[6:0]};
      digit_sel_d = oh_s[DIGITS-1:0];
    end else begin
      seg_out_d   = 8'h00;
      digit_sel_d = '0;
    end
  end

  // State, counters, frame snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      val_q        <= '0;
      dp_q         <= '0;
      mask_q       <= '0;
      seg_out_q    <= 8'h00;
      digit_sel_q  <= '0;
      digit_code_q <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      val_q        <= val_d;
      dp_q         <= dp_d;
      mask_q       <= mask_d;
      seg_out_q    <= seg_out_d;
      digit_sel_q  <= digit_sel_d;
      digit_code_q <= digit_code_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign digit_sel  = digit_sel_q;
  assign digit_code = digit_code_q;
  assign frame_done = frame_done_q;

endmodule
